// File: rtl/ns_gnrl_wrr_arbiter.sv
// ns_gnrl_wrr_arbiter
//   Weighted round-robin arbiter with packet locking and a valid/ready grant
//   handshake. A requester keeps the grant for whole packets, up to weight+1
//   packets per turn, before the round-robin pointer moves past it.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   arbt_ena    : global enable; low freezes state and blanks the grant
//   req_vec     : per-requester beat request
//   req_last    : per-requester last-beat flag (meaningful with req_vec)
//   wgt         : packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
//   out_rdy     : downstream accepts the granted beat
//   grt_vld     : grant presented this cycle
//   grt_vec     : one-hot grant (zero when grt_vld=0)
//   grt_id      : binary grant index (zero when grt_vld=0)
//   grt_last    : req_last of the granted requester (zero when grt_vld=0)
//   busy        : arbiter is inside a packet or a turn (state != IDLE)
module ns_gnrl_wrr_arbiter #(
  parameter int unsigned ARBT_NUM = 4,
  parameter int unsigned WEIGHT_W = 3,
  parameter int unsigned ID_W     = $clog2(ARBT_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arbt_ena,
  input  logic [ARBT_NUM-1:0]          req_vec,
  input  logic [ARBT_NUM-1:0]          req_last,
  input  logic [ARBT_NUM*WEIGHT_W-1:0] wgt,
  input  logic                         out_rdy,
  output logic                         grt_vld,
  output logic [ARBT_NUM-1:0]          grt_vec,
  output logic [ID_W-1:0]              grt_id,
  output logic                         grt_last,
  output logic                         busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PKT  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [WEIGHT_W-1:0] wgt_arr [ARBT_NUM];

  always_comb begin
    for (int i = 0; i < ARBT_NUM; i++) begin
      wgt_arr[i] = wgt[i*WEIGHT_W +: WEIGHT_W];
    end
  end

  // Round-robin pick: rotate the request vector so ptr lands on bit 0, take
  // the first set bit, then map the offset back to an absolute index.
  logic [2*ARBT_NUM-1:0] req_rot;
  logic                  rr_found;
  logic [ID_W-1:0]       rr_idx;
  logic [ID_W:0]         rr_sum;

  always_comb begin
    req_rot  = {req_vec, req_vec} >> ptr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int k = 0; k < ARBT_NUM; k++) begin
      if (!rr_found && req_rot[k]) begin
        rr_found = 1'b1;
        rr_sum   = (ID_W+1)'(ptr_q) + (ID_W+1)'(k);
        if (rr_sum >= (ID_W+1)'(ARBT_NUM)) begin
          rr_sum = rr_sum - (ID_W+1)'(ARBT_NUM);
        end
        rr_idx = rr_sum[ID_W-1:0];
      end
    end
  end

  // Grant selection from registered state and live requests.
  logic            gnt_ok;
  logic            gnt_raw;
  logic [ID_W-1:0] gnt_idx;

  always_comb begin
    gnt_raw = 1'b0;
    gnt_idx = '0;
    case (state_q)
      ST_PKT: begin
        // Locked: non-owners are ignored even while the owner bubbles.
        gnt_raw = req_vec[owner_q];
        gnt_idx = owner_q;
      end
      ST_GAP: begin
        if (req_vec[owner_q]) begin
          gnt_raw = 1'b1;
          gnt_idx = owner_q;
        end else begin
          gnt_raw = rr_found;
          gnt_idx = rr_idx;
        end
      end
      default: begin
        gnt_raw = rr_found;
        gnt_idx = rr_idx;
      end
    endcase
  end

  // Outputs are blanked asynchronously by reset as well as by the enable.
  assign gnt_ok   = arbt_ena & rst_n;
  assign grt_vld  = gnt_ok & gnt_raw;
  assign grt_id   = grt_vld ? gnt_idx : '0;
  assign grt_vec  = grt_vld ? (ARBT_NUM'(1) << gnt_idx) : '0;
  assign grt_last = grt_vld & req_last[gnt_idx];
  assign busy     = (state_q != ST_IDLE);

  logic                xfer;
  logic                new_own;
  logic [WEIGHT_W-1:0] cr;

  assign xfer = grt_vld & out_rdy;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    new_own  = 1'b0;
    cr       = credit_q;
    if (xfer) begin
      new_own = (state_q == ST_IDLE) || (state_q == ST_GAP && gnt_idx != owner_q);
      // Quota is latched only when a requester takes ownership.
      cr      = new_own ? wgt_arr[gnt_idx] : credit_q;
      owner_d = gnt_idx;
      if (!grt_last) begin
        state_d  = ST_PKT;
        credit_d = cr;
      end else if (cr == '0) begin
        state_d  = ST_IDLE;
        credit_d = '0;
        ptr_d    = (gnt_idx == ID_W'(ARBT_NUM-1)) ? '0 : gnt_idx + ID_W'(1);
      end else begin
        state_d  = ST_GAP;
        credit_d = cr - WEIGHT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

endmodule
